// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle sequencer and HI/LO owner for the E-stage
// multiply/divide unit.
//   clk, reset_n    core clock, synchronous active-low reset
//   En, Ctrl        E-stage MDU enable and operation code
//   A, B            forwarded rs / rt operands
//   DUsesMDU        D-stage instruction touches the MDU
//   Busy            operation in flight (registered)
//   Stall           stall request to the hazard unit (combinational)
//   HI, LO          architectural HI/LO registers
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        En,
  input  logic [2:0]  Ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        DUsesMDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // MDUCtrl codes, mirroring define.v; 0 and 7 are no-ops.
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic        start, commit;
  logic        op_mul, op_div, op_signed;

  assign op_mul    = (Ctrl == MDU_MULT) || (Ctrl == MDU_MULTU);
  assign op_div    = (Ctrl == MDU_DIV)  || (Ctrl == MDU_DIVU);
  assign op_signed = (Ctrl == MDU_MULT) || (Ctrl == MDU_DIV);
  assign start     = En && (op_mul || op_div) && (state_q == S_IDLE);

  assign Busy  = (state_q != S_IDLE);
  assign Stall = DUsesMDU && (Busy || start);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = op_div ? S_DIV : S_MUL;
          cnt_d   = op_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multiply: low 64 bits of the product of sign-extended (signed op) or
  // zero-extended (unsigned op) operands give the correct 64-bit result.
  logic [63:0] a_ext, b_ext, prod;
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero, remainder follows the dividend. 0x80000000 / -1 falls out as
  // q=0x80000000, r=0 without a special case.
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  assign a_neg  = sgn_q & a_q[31];
  assign b_neg  = sgn_q & b_q[31];
  assign a_mag  = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag  = b_neg ? (32'd0 - b_q) : b_q;
  assign b_zero = (b_q == '0);
  assign b_safe = b_zero ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      if (start) begin
        a_q   <= A;
        b_q   <= B;
        sgn_q <= op_signed;
      end
      if (commit) begin
        if (state_q == S_MUL) begin
          HI <= prod[63:32];
          LO <= prod[31:0];
        end else if (!b_zero) begin
          HI <= rem;
          LO <= quo;
        end
      end
      if (En && (state_q == S_IDLE)) begin
        if (Ctrl == MDU_MTHI) HI <= A;
        if (Ctrl == MDU_MTLO) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam logic [2:0] C_MULT  = 3'd1;
  localparam logic [2:0] C_MULTU = 3'd2;
  localparam logic [2:0] C_DIV   = 3'd3;
  localparam logic [2:0] C_DIVU  = 3'd4;
  localparam logic [2:0] C_MTHI  = 3'd5;
  localparam logic [2:0] C_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        En;
  logic [2:0]  Ctrl;
  logic [31:0] A, B;
  logic        DUsesMDU;
  logic        Busy, Stall;
  logic [31:0] HI, LO;

  int nvec = 0;
  int nbad = 0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .En       (En),
    .Ctrl     (Ctrl),
    .A        (A),
    .B        (B),
    .DUsesMDU (DUsesMDU),
    .Busy     (Busy),
    .Stall    (Stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, count busy cycles (bounded), check stall behaviour
  // and final HI/LO.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic dus, input int ncyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int stall_bad;
    n = 0;
    stall_bad = 0;
    En = 1'b1; Ctrl = c; A = a; B = b; DUsesMDU = dus;
    #1;
    chk({tag, "_stall_start"}, {31'd0, Stall}, {31'd0, dus});
    tick();
    En = 1'b0; Ctrl = 3'd0; A = 32'h5A5A_A5A5; B = 32'hFFFF_0001;
    for (int i = 0; i < 20 && Busy; i++) begin
      n++;
      if (Stall !== dus) stall_bad++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(ncyc));
    chk({tag, "_stall_busy"}, 32'(stall_bad), 32'd0);
    chk({tag, "_stall_after"}, {31'd0, Stall}, 32'd0);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
    DUsesMDU = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; En = 1'b1; Ctrl = C_MULT; A = 32'd5; B = 32'd5; DUsesMDU = 1'b0;
    tick();
    tick();
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    reset_n = 1'b1; En = 1'b0; Ctrl = 3'd0;
    tick();
    chk("post_rst_busy", {31'd0, Busy}, 32'd0);

    run_op("mult",  C_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", C_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   C_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", C_DIVU,  32'd7,         32'd0, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divovf", C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000);
    run_op("divneg", C_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("divu",  C_DIVU,  32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14);

    // mthi / mtlo while idle
    En = 1'b1; Ctrl = C_MTHI; A = 32'h1234_5678;
    tick();
    En = 1'b0; Ctrl = 3'd0;
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'd14);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    En = 1'b1; Ctrl = C_MTLO; A = 32'hCAFE_F00D;
    tick();
    En = 1'b0; Ctrl = 3'd0;
    chk("mtlo_lo", LO, 32'hCAFE_F00D);
    chk("mtlo_hi", HI, 32'h1234_5678);

    // no-op and undefined codes
    En = 1'b1; Ctrl = 3'd0; A = 32'h1111_1111; B = 32'd2;
    tick();
    Ctrl = 3'd7;
    tick();
    En = 1'b0;
    chk("noop_busy", {31'd0, Busy}, 32'd0);
    chk("noop_hi", HI, 32'h1234_5678);
    chk("noop_lo", LO, 32'hCAFE_F00D);

    // requests while busy are ignored: mtlo then a div during a mult
    En = 1'b1; Ctrl = C_MULT; A = 32'd5; B = 32'd6;
    tick();
    n = 1;
    Ctrl = C_MTLO; A = 32'hDEAD_BEEF;
    tick();
    n++;
    chk("busy_mtlo_lo", LO, 32'hCAFE_F00D);
    Ctrl = C_DIV; A = 32'd9; B = 32'd3;
    tick();
    n++;
    En = 1'b0; Ctrl = 3'd0;
    for (int i = 0; i < 20 && Busy; i++) begin
      n++;
      tick();
    end
    chk("busy_ign_cycles", 32'(n - 1), 32'd5);
    chk("busy_ign_hi", HI, 32'd0);
    chk("busy_ign_lo", LO, 32'd30);

    // reset in the middle of a divide
    En = 1'b1; Ctrl = C_DIVU; A = 32'd100; B = 32'd7;
    tick();
    En = 1'b0; Ctrl = 3'd0;
    tick();
    tick();
    tick();
    chk("midrst_busy_before", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("midrst_late_hi", HI, 32'd0);
    chk("midrst_late_lo", LO, 32'd0);
    chk("midrst_late_busy", {31'd0, Busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
